// File: rtl/writeback_arbiter_if.sv
// -----------------------------------------------------------------------------
// writeback_arbiter_if
// Bundle between the execution units, the writeback arbiter and the
// register file / csr consumers.
//   Producer side : res_v, res, res_rd, res_exc (per unit), flush
//   Grant         : ok_o (one-hot accept back to the producers)
//   Commit side   : wb_v, wb_rd, wb_data, exc_v, exc_unit, instret_v
// Modports:
//   master : the environment (producers + consumers)
//   slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface writeback_arbiter_if #(
    parameter int NUNITS = 4,
    parameter int DATA_W = 32
);
    localparam int UW = $clog2(NUNITS);

    logic [NUNITS-1:0]        res_v;
    logic [NUNITS*DATA_W-1:0] res;
    logic [NUNITS*5-1:0]      res_rd;
    logic [NUNITS-1:0]        res_exc;
    logic [NUNITS-1:0]        ok_o;
    logic                     flush;
    logic                     wb_v;
    logic [4:0]               wb_rd;
    logic [DATA_W-1:0]        wb_data;
    logic                     exc_v;
    logic [UW-1:0]            exc_unit;
    logic                     instret_v;

    modport master (
        output res_v, res, res_rd, res_exc, flush,
        input  ok_o, wb_v, wb_rd, wb_data, exc_v, exc_unit, instret_v
    );

    modport slave (
        input  res_v, res, res_rd, res_exc, flush,
        output ok_o, wb_v, wb_rd, wb_data, exc_v, exc_unit, instret_v
    );
endinterface

// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
// Commit stage behind the execution units. Each cycle one valid producer is
// granted round-robin; its result is registered onto the register-file write
// port, or reported as an exception, and a retire pulse is sent to the csr.
// Ports:
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   bus    : writeback_arbiter_if.slave
//            in  res_v/res/res_rd/res_exc per unit, flush
//            out ok_o (combinational one-hot accept)
//            out wb_v/wb_rd/wb_data, exc_v/exc_unit, instret_v (registered)
// -----------------------------------------------------------------------------
module writeback_arbiter #(
    parameter int NUNITS = 4,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    writeback_arbiter_if.slave    bus
);
    localparam int UW = $clog2(NUNITS);

    logic [UW-1:0]     r_rr;
    logic [UW-1:0]     w_g;
    logic              w_found;
    logic              w_grant_v;
    logic [NUNITS-1:0] w_ok;
    int                w_scan;
    logic [4:0]        w_sel_rd;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_sel_exc;
    logic [UW-1:0]     w_rr_next;

    logic              r_wb_v_p1;
    logic [4:0]        r_wb_rd_p1;
    logic [DATA_W-1:0] r_wb_data_p1;
    logic              r_exc_v_p1;
    logic [UW-1:0]     r_exc_unit_p1;
    logic              r_vld_p1;

    // ---- stage p0: round-robin scan starting at r_rr ----
    always_comb begin
        w_found = 1'b0;
        w_g     = '0;
        w_scan  = 0;
        for (int k = 0; k < NUNITS; k++) begin
            w_scan = int'(r_rr) + k;
            if (w_scan >= NUNITS) w_scan = w_scan - NUNITS;
            if (!w_found && bus.res_v[w_scan]) begin
                w_found = 1'b1;
                w_g     = UW'(w_scan);
            end
        end
    end

    // A flush or reset suppresses the accept so producers keep their data.
    assign w_grant_v  = w_found & ~bus.flush & rst_n;
    assign w_ok       = w_grant_v ? (NUNITS'(1) << w_g) : '0;
    assign bus.ok_o   = w_ok;

    assign w_sel_rd   = bus.res_rd[w_g*5 +: 5];
    assign w_sel_data = bus.res[w_g*DATA_W +: DATA_W];
    assign w_sel_exc  = bus.res_exc[w_g];
    assign w_rr_next  = (w_g == UW'(NUNITS-1)) ? '0 : w_g + UW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr <= '0;
        end else if (bus.flush) begin
            r_rr <= '0;
        end else if (w_grant_v) begin
            r_rr <= w_rr_next;
        end
    end

    // ---- stage p1: registered commit ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb_v_p1     <= 1'b0;
            r_wb_rd_p1    <= '0;
            r_wb_data_p1  <= '0;
            r_exc_v_p1    <= 1'b0;
            r_exc_unit_p1 <= '0;
            r_vld_p1      <= 1'b0;
        end else if (w_grant_v) begin
            // x0 writes are dropped but the instruction still retires.
            r_wb_v_p1    <= ~w_sel_exc & (w_sel_rd != 5'd0);
            r_wb_rd_p1   <= w_sel_rd;
            r_wb_data_p1 <= w_sel_data;
            r_exc_v_p1   <= w_sel_exc;
            r_vld_p1     <= ~w_sel_exc;
            if (w_sel_exc) r_exc_unit_p1 <= w_g;
        end else begin
            r_wb_v_p1  <= 1'b0;
            r_exc_v_p1 <= 1'b0;
            r_vld_p1   <= 1'b0;
        end
    end

    assign bus.wb_v      = r_wb_v_p1;
    assign bus.wb_rd     = r_wb_rd_p1;
    assign bus.wb_data   = r_wb_data_p1;
    assign bus.exc_v     = r_exc_v_p1;
    assign bus.exc_unit  = r_exc_unit_p1;
    assign bus.instret_v = r_vld_p1;
endmodule

// File: tb/tb_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_writeback_arbiter
// Directed bench for writeback_arbiter with a small reference model: each
// step predicts the grant and the registered commit, queues the expected
// commit, and compares it one clock later.
// -----------------------------------------------------------------------------
module tb_writeback_arbiter;
    localparam int NUNITS = 4;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic        wb_v;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        exc_v;
        logic [1:0]  exc_unit;
        logic        instret_v;
    } exp_t;

    logic clk;
    logic rst_n;
    writeback_arbiter_if #(.NUNITS(NUNITS), .DATA_W(DATA_W)) bus ();

    writeback_arbiter #(.NUNITS(NUNITS), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    logic [31:0] t_data[NUNITS];
    logic [4:0]  t_rd[NUNITS];
    logic [1:0]  m_rr = 2'd0;
    logic [4:0]  m_wb_rd = '0;
    logic [31:0] m_wb_data = '0;
    logic [1:0]  m_exc_unit = '0;
    logic [3:0]  last_ok;
    int          pulses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus (called just after a negedge), check the
    // combinational accept before the posedge, then the commit after it.
    task automatic step(input logic rstn, input logic fl, input logic [3:0] v,
                        input logic [3:0] ex);
        exp_t e;
        exp_t got;
        logic found;
        logic [1:0] g;
        logic gv;
        logic [3:0] m_ok;
        rst_n       = rstn;
        bus.flush   = fl;
        bus.res_v   = v;
        bus.res_exc = ex;
        for (int i = 0; i < NUNITS; i++) begin
            bus.res[i*DATA_W +: DATA_W] = t_data[i];
            bus.res_rd[i*5 +: 5]        = t_rd[i];
        end
        found = 1'b0;
        g     = 2'd0;
        for (int k = 0; k < NUNITS; k++) begin
            if (!found && v[(int'(m_rr) + k) % NUNITS]) begin
                found = 1'b1;
                g     = 2'((int'(m_rr) + k) % NUNITS);
            end
        end
        gv   = found && !fl && rstn;
        m_ok = gv ? (4'b0001 << g) : 4'b0000;
        e    = '0;
        if (!rstn) begin
            m_rr = 2'd0; m_wb_rd = '0; m_wb_data = '0; m_exc_unit = '0;
        end else begin
            if (gv) begin
                m_wb_rd   = t_rd[g];
                m_wb_data = t_data[g];
                if (ex[g]) m_exc_unit = g;
                e.wb_v      = !ex[g] && (t_rd[g] != 5'd0);
                e.exc_v     = ex[g];
                e.instret_v = !ex[g];
                m_rr        = 2'((int'(g) + 1) % NUNITS);
            end
            if (fl) m_rr = 2'd0;
        end
        e.wb_rd    = m_wb_rd;
        e.wb_data  = m_wb_data;
        e.exc_unit = m_exc_unit;
        q.push_back(e);

        #4;
        last_ok = bus.ok_o;
        chk("ok_o", 32'(bus.ok_o), 32'(m_ok));
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("queue_empty", 32'd0, 32'd1);
        end else begin
            got = q.pop_front();
            chk("wb_v",      32'(bus.wb_v),      32'(got.wb_v));
            chk("wb_rd",     32'(bus.wb_rd),     32'(got.wb_rd));
            chk("wb_data",   bus.wb_data,        got.wb_data);
            chk("exc_v",     32'(bus.exc_v),     32'(got.exc_v));
            chk("exc_unit",  32'(bus.exc_unit),  32'(got.exc_unit));
            chk("instret_v", 32'(bus.instret_v), 32'(got.instret_v));
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.flush   = 1'b0;
        bus.res_v   = '0;
        bus.res_exc = '0;
        bus.res     = '0;
        bus.res_rd  = '0;
        for (int i = 0; i < NUNITS; i++) begin
            t_data[i] = 32'h1000_0000 + 32'(i);
            t_rd[i]   = 5'(i + 1);
        end
        @(negedge clk);

        // Reset held two cycles with all units requesting.
        step(1'b0, 1'b0, 4'hF, 4'h0);
        step(1'b0, 1'b0, 4'hF, 4'h0);
        chk("rst_ok",      32'(last_ok),       32'd0);
        chk("rst_wb_v",    32'(bus.wb_v),      32'd0);
        chk("rst_exc_v",   32'(bus.exc_v),     32'd0);
        chk("rst_instret", 32'(bus.instret_v), 32'd0);

        // Single write from unit 2.
        t_data[2] = 32'hDEADBEEF;
        t_rd[2]   = 5'd7;
        step(1'b1, 1'b0, 4'b0100, 4'h0);
        chk("t2_ok",      32'(last_ok),       32'h4);
        chk("t2_wb_v",    32'(bus.wb_v),      32'd1);
        chk("t2_wb_rd",   32'(bus.wb_rd),     32'd7);
        chk("t2_wb_data", bus.wb_data,        32'hDEADBEEF);
        chk("t2_instret", 32'(bus.instret_v), 32'd1);

        // Flush with everything valid: no grant, pointer back to 0.
        step(1'b1, 1'b1, 4'hF, 4'h0);
        chk("fl_ok",      32'(last_ok),       32'd0);
        chk("fl_instret", 32'(bus.instret_v), 32'd0);

        // Fairness: all valid for 8 cycles, rotation 0,1,2,3,0,1,2,3.
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 4'hF, 4'h0);
            chk("rot_grant", 32'(last_ok), 32'(4'b0001 << (i % 4)));
            pulses += int'(bus.instret_v);
        end
        chk("rot_pulses", 32'(pulses), 32'd8);

        // x0 destination: retires without a write.
        t_rd[1]   = 5'd0;
        t_data[1] = 32'h5;
        step(1'b1, 1'b0, 4'b0010, 4'h0);
        chk("x0_wb_v",    32'(bus.wb_v),      32'd0);
        chk("x0_instret", 32'(bus.instret_v), 32'd1);

        // Exception from unit 2, then a normal commit from unit 0.
        t_rd[2] = 5'd3;
        step(1'b1, 1'b0, 4'b0100, 4'b0100);
        chk("exc_wb_v",    32'(bus.wb_v),      32'd0);
        chk("exc_instret", 32'(bus.instret_v), 32'd0);
        chk("exc_v",       32'(bus.exc_v),     32'd1);
        chk("exc_unit",    32'(bus.exc_unit),  32'd2);
        t_rd[0]   = 5'd9;
        t_data[0] = 32'hABCD_0000;
        step(1'b1, 1'b0, 4'b0001, 4'h0);
        chk("post_exc_wb_v",  32'(bus.wb_v),  32'd1);
        chk("post_exc_wb_rd", 32'(bus.wb_rd), 32'd9);
        chk("post_exc_exc_v", 32'(bus.exc_v), 32'd0);

        // Flush after a grant to unit 1 returns the pointer to 0.
        t_rd[1]   = 5'd4;
        t_data[1] = 32'h11;
        step(1'b1, 1'b0, 4'b0010, 4'h0);
        step(1'b1, 1'b1, 4'b1000, 4'h0);
        chk("t6_fl_ok",      32'(last_ok),       32'd0);
        chk("t6_fl_wb_v",    32'(bus.wb_v),      32'd0);
        chk("t6_fl_instret", 32'(bus.instret_v), 32'd0);
        chk("t6_fl_hold_rd", 32'(bus.wb_rd),     32'd4);
        step(1'b1, 1'b0, 4'b1001, 4'h0);
        chk("t6_after_ok", 32'(last_ok), 32'h1);

        // Idle cycle: pulses drop, data holds.
        step(1'b1, 1'b0, 4'h0, 4'h0);

        // Reset while a grant is pending: commit lost, pointer to 0.
        step(1'b0, 1'b0, 4'b0100, 4'h0);
        chk("rstp_wb_data", bus.wb_data,        32'd0);
        chk("rstp_instret", 32'(bus.instret_v), 32'd0);
        step(1'b1, 1'b0, 4'hF, 4'h0);
        chk("rstp_next_ok", 32'(last_ok), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
